sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning word-address width of internal RAM (1024 x 16).
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..7, meaning extra read cycles before data is valid.
REQ-003 SHALL have parameter INIT_LEN, default 64, range 1..2**DEPTH_LOG2, meaning words preloaded from program ROM after reset.
REQ-004 SHALL have one clock and synchronous active-low reset: Clk  input  1  rising-edge clock.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port ADDR  input  16  word address driven by CPU MAR.
REQ-007 SHALL have port OE  input  1  active-low read enable.
REQ-008 SHALL have port WE  input  1  active-low write enable.
REQ-009 SHALL have port Data_to_SRAM  input  16  write data from CPU.
REQ-010 SHALL have port Data_from_SRAM  output  16  registered read data to CPU.
REQ-011 SHALL have port Ready  output  1  one-cycle pulse that the access completed.
REQ-012 SHALL have port Init_Done  output  1  high once preload finishes; stays high until next reset.

Function
REQ-013 SHALL implement states INIT, IDLE, READ, RESP, WR_ACK.
REQ-014 INIT: SHALL write program_rom[i] to RAM[i] for i = 0..INIT_LEN-1, one word per cycle; OE/WE ignored; enter IDLE after word INIT_LEN-1, Init_Done rising at that same edge.
REQ-015 IDLE, WE low at edge N: SHALL write Data_to_SRAM to RAM[ADDR] at edge N, enter WR_ACK, Ready high for the cycle after edge N.
REQ-016 IDLE, OE low and WE high at edge N: SHALL latch ADDR; Data_from_SRAM and Ready SHALL become valid at edge N+1+WAIT_STATES (READ holds WAIT_STATES cycles, then RESP).
REQ-017 OE and WE both low: write SHALL win; Data_from_SRAM unchanged.
REQ-018 Ready SHALL be high exactly one cycle per completed access; RESP/WR_ACK SHALL return to IDLE; a new access is accepted at the following edge.
REQ-019 Data_from_SRAM SHALL hold its last read value until the next completed read.
REQ-020 OE deasserting during READ SHALL abort: return to IDLE, no Ready pulse, Data_from_SRAM unchanged.
REQ-021 ADDR changes during READ SHALL be ignored; the latched address is used.
REQ-022 Out-of-range address (ADDR[15:DEPTH_LOG2] nonzero): reads SHALL return 16'h0000 with normal latency; writes SHALL not modify RAM; Ready SHALL pulse normally.
REQ-023 Write-then-read of the same address SHALL return the newly written value.
REQ-024 WE held low for consecutive accesses SHALL produce one write per IDLE visit (every second cycle).

Reset
REQ-025 Reset low at any edge SHALL force INIT with preload index 0, Data_from_SRAM = 16'h0000, Ready = 0, Init_Done = 0, wait counter = 0.
REQ-026 Reset mid-access SHALL abort the access without a Ready pulse; RAM words >= INIT_LEN SHALL retain contents.

Structure
REQ-027 Shared package sram_pkg SHALL hold the state enum, default DEPTH_LOG2/WAIT_STATES/INIT_LEN constants, and the 16-bit word typedef.
REQ-028 Preload contents SHALL live in one sub-module, program_rom (combinational index-to-word lookup); RAM array and FSM SHALL stay in sram_responder.

Verification
REQ-029 Reset released, INIT_LEN=64 -> Init_Done rises 64 cycles later; RAM[0..63] equals program_rom; OE low in INIT ignored.
REQ-030 Write 16'hBEEF to 16'h0100, then read 16'h0100 with WAIT_STATES=1 -> Ready at write edge+1; read data 16'hBEEF and Ready at read edge+2.
REQ-031 Read 16'hFFFF -> Data_from_SRAM = 16'h0000, Ready pulses; write 16'h1234 to 16'h8000 -> RAM[16'h0000] unchanged.
REQ-032 OE and WE both low, ADDR 16'h0010, data 16'h5A5A -> RAM[16'h10] = 16'h5A5A, Data_from_SRAM unchanged, one Ready.
REQ-033 WAIT_STATES=3, OE raised one cycle after read start -> no Ready, FSM in IDLE; next read of 16'h0001 completes in 4 cycles.
REQ-034 Reset asserted during READ -> Ready stays 0, outputs zero, INIT restarts, RAM[16'h0200] written earlier retains its value.

Source files
------------

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM responder slice:
//   - default geometry / timing constants
//   - 16-bit word type
//   - responder FSM state encoding
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam int DEF_DEPTH_LOG2  = 10;
  localparam int DEF_WAIT_STATES = 1;
  localparam int DEF_INIT_LEN    = 64;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ,
    RESP,
    WR_ACK
  } state_t;

endpackage

// File: rtl/sram_responder_program_rom.sv
// -----------------------------------------------------------------------------
// program_rom
// Combinational preload image for the SRAM responder. Each index maps to a
// fixed program word; the responder walks this table after reset.
// Ports:
//   index : word index being preloaded (DEPTH_LOG2 bits)
//   word  : program word for that index
// -----------------------------------------------------------------------------
module program_rom
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic [DEPTH_LOG2-1:0] index,
  output word_t                 word
);

  // Program image: 16'h8000 + 17*index. Every word is distinct and has the
  // top bit set, so a preloaded word never looks like an erased/zero word.
  always_comb begin
    word = 16'h8000 + (16'(index) * 16'd17);
  end

endmodule

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Single-port SRAM model answering CPU read/write strobes. After reset it
// copies INIT_LEN words from program_rom into RAM, then serves accesses.
// Ports:
//   Clk            : rising-edge clock
//   Reset          : synchronous active-low reset
//   ADDR           : word address from CPU MAR
//   OE             : active-low read enable
//   WE             : active-low write enable (wins over OE)
//   Data_to_SRAM   : write data
//   Data_from_SRAM : registered read data, held until the next completed read
//   Ready          : one-cycle pulse per completed access
//   Init_Done      : high once preload finished, until next reset
// -----------------------------------------------------------------------------
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int INIT_LEN    = DEF_INIT_LEN
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_to_SRAM,
  output logic [15:0] Data_from_SRAM,
  output logic        Ready,
  output logic        Init_Done
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX  = DEPTH_LOG2'(INIT_LEN - 1);
  localparam logic [2:0]            WAIT_LAST = 3'(WAIT_STATES);

  word_t                 ram [DEPTH];

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] init_idx, init_idx_next;
  logic [2:0]            wait_cnt, wait_cnt_next;
  logic [15:0]           addr_q, addr_q_next;

  word_t                 rom_word;
  word_t                 read_word;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  word_t                 ram_wdata;
  logic                  load_read;
  logic                  set_ready;
  logic                  set_init_done;

  program_rom #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_program_rom (
    .index(init_idx),
    .word (rom_word)
  );

  // Any address bit above the RAM width makes the access out of range.
  function automatic logic in_range(input logic [15:0] a);
    return (a >> DEPTH_LOG2) == 16'h0000;
  endfunction

  assign read_word = in_range(addr_q) ? ram[addr_q[DEPTH_LOG2-1:0]] : 16'h0000;

  // Next-state logic. The read address is captured at the start of a read so
  // ADDR may wander while the wait states elapse.
  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    wait_cnt_next = wait_cnt;
    addr_q_next   = addr_q;
    ram_we        = 1'b0;
    ram_waddr     = init_idx;
    ram_wdata     = rom_word;
    load_read     = 1'b0;
    set_ready     = 1'b0;
    set_init_done = 1'b0;

    case (state)
      INIT: begin
        ram_we = 1'b1;
        if (init_idx == LAST_IDX) begin
          state_next    = IDLE;
          set_init_done = 1'b1;
        end else begin
          init_idx_next = init_idx + 1'b1;
        end
      end

      IDLE: begin
        if (!WE) begin
          ram_we     = in_range(ADDR);
          ram_waddr  = ADDR[DEPTH_LOG2-1:0];
          ram_wdata  = Data_to_SRAM;
          set_ready  = 1'b1;
          state_next = WR_ACK;
        end else if (!OE) begin
          addr_q_next   = ADDR;
          wait_cnt_next = '0;
          state_next    = READ;
        end
      end

      // Dropping OE mid-read abandons the access silently.
      READ: begin
        if (OE) begin
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          load_read  = 1'b1;
          set_ready  = 1'b1;
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end

      RESP, WR_ACK: begin
        state_next = IDLE;
      end

      default: begin
        state_next = INIT;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state          <= INIT;
      init_idx       <= '0;
      wait_cnt       <= '0;
      addr_q         <= '0;
      Data_from_SRAM <= '0;
      Ready          <= 1'b0;
      Init_Done      <= 1'b0;
    end else begin
      state    <= state_next;
      init_idx <= init_idx_next;
      wait_cnt <= wait_cnt_next;
      addr_q   <= addr_q_next;
      Ready    <= set_ready;
      if (load_read) begin
        Data_from_SRAM <= read_word;
      end
      if (set_init_done) begin
        Init_Done <= 1'b1;
      end
    end
  end

  // RAM contents are never cleared by reset; only the preload rewrites the
  // low INIT_LEN words.
  always_ff @(posedge Clk) begin
    if (Reset && ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
// Directed bench for sram_responder. Two instances share clock and reset:
// dut_ws1 (WAIT_STATES=1) and dut_ws3 (WAIT_STATES=3), both INIT_LEN=64.
// Program image expected: 16'h8000 + 17*index.
// -----------------------------------------------------------------------------
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        a_oe, a_we, a_ready, a_init_done;
  logic [15:0] b_addr, b_wdata, b_rdata;
  logic        b_oe, b_we, b_ready, b_init_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_responder #(
    .DEPTH_LOG2 (10),
    .WAIT_STATES(1),
    .INIT_LEN   (64)
  ) dut_ws1 (
    .Clk           (clk),
    .Reset         (reset_n),
    .ADDR          (a_addr),
    .OE            (a_oe),
    .WE            (a_we),
    .Data_to_SRAM  (a_wdata),
    .Data_from_SRAM(a_rdata),
    .Ready         (a_ready),
    .Init_Done     (a_init_done)
  );

  sram_responder #(
    .DEPTH_LOG2 (10),
    .WAIT_STATES(3),
    .INIT_LEN   (64)
  ) dut_ws3 (
    .Clk           (clk),
    .Reset         (reset_n),
    .ADDR          (b_addr),
    .OE            (b_oe),
    .WE            (b_we),
    .Data_to_SRAM  (b_wdata),
    .Data_from_SRAM(b_rdata),
    .Ready         (b_ready),
    .Init_Done     (b_init_done)
  );

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
    end
  endtask

  // sel=0 drives dut_ws1, sel=1 drives dut_ws3.
  task automatic applyStimulus(input bit sel, input logic [15:0] addr, input logic oe,
                               input logic we, input logic [15:0] wdata);
    if (sel) begin
      b_addr = addr; b_oe = oe; b_we = we; b_wdata = wdata;
    end else begin
      a_addr = addr; a_oe = oe; a_we = we; a_wdata = wdata;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  function automatic logic [15:0] rdata(input bit sel);
    return sel ? b_rdata : a_rdata;
  endfunction

  // Full read: Ready/data must appear exactly WAIT_STATES+1 edges after the
  // accepting edge, and the data must hold after returning to idle.
  task automatic readWord(input bit sel, input logic [15:0] addr,
                          input logic [15:0] expected, input string tag);
    int ws;
    ws = sel ? 3 : 1;
    applyStimulus(sel, addr, 1'b0, 1'b1, 16'h0000);
    step();
    checkBit({tag, " ready at accept"}, rdy(sel), 1'b0);
    for (int k = 0; k < ws; k++) begin
      step();
      checkBit({tag, " ready early"}, rdy(sel), 1'b0);
    end
    step();
    checkBit({tag, " ready"}, rdy(sel), 1'b1);
    checkOutput({tag, " data"}, rdata(sel), expected);
    applyStimulus(sel, addr, 1'b1, 1'b1, 16'h0000);
    step();
    checkBit({tag, " ready drop"}, rdy(sel), 1'b0);
    checkOutput({tag, " data hold"}, rdata(sel), expected);
  endtask

  task automatic writeWord(input bit sel, input logic [15:0] addr,
                           input logic [15:0] data, input string tag);
    applyStimulus(sel, addr, 1'b1, 1'b0, data);
    step();
    checkBit({tag, " ready"}, rdy(sel), 1'b1);
    applyStimulus(sel, addr, 1'b1, 1'b1, data);
    step();
    checkBit({tag, " ready drop"}, rdy(sel), 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000);
    step();
    step();
    checkOutput("reset rdata", a_rdata, 16'h0000);
    checkBit("reset ready", a_ready, 1'b0);
    checkBit("reset init_done", a_init_done, 1'b0);
    checkBit("reset init_done ws3", b_init_done, 1'b0);

    // Preload: OE held low throughout must be ignored.
    reset_n = 1'b1;
    a_oe    = 1'b0;
    b_oe    = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step();
      checkBit("init_done timing", a_init_done, (k == 64));
      checkBit("ready during init", a_ready, 1'b0);
    end
    a_oe = 1'b1;
    b_oe = 1'b1;
    checkBit("init_done ws3", b_init_done, 1'b1);
    checkOutput("rdata after init", a_rdata, 16'h0000);

    // Hand-computed preload spots, then the whole image.
    readWord(1'b0, 16'h0000, 16'h8000, "rom0");
    readWord(1'b0, 16'h0010, 16'h8110, "rom16");
    readWord(1'b0, 16'h003F, 16'h842F, "rom63");
    for (int i = 0; i < 64; i++) begin
      readWord(1'b0, 16'(i), 16'h8000 + 16'(i * 17), "rom sweep");
    end

    // Write then read back with one wait state.
    writeWord(1'b0, 16'h0100, 16'hBEEF, "wr 0100");
    readWord(1'b0, 16'h0100, 16'hBEEF, "rd 0100");

    // Out-of-range accesses.
    readWord(1'b0, 16'hFFFF, 16'h0000, "rd ffff");
    writeWord(1'b0, 16'h8000, 16'h1234, "wr 8000");
    readWord(1'b0, 16'h0000, 16'h8000, "rd 0000 after oor wr");

    // OE and WE both low: write wins, read data untouched, single Ready.
    readWord(1'b0, 16'h0001, 16'h8011, "rd 0001");
    applyStimulus(1'b0, 16'h0010, 1'b0, 1'b0, 16'h5A5A);
    step();
    checkBit("both low ready", a_ready, 1'b1);
    checkOutput("both low rdata", a_rdata, 16'h8011);
    applyStimulus(1'b0, 16'h0010, 1'b1, 1'b1, 16'h0000);
    step();
    checkBit("both low ready drop", a_ready, 1'b0);
    checkOutput("both low rdata hold", a_rdata, 16'h8011);
    step();
    checkBit("both low single ready", a_ready, 1'b0);
    readWord(1'b0, 16'h0010, 16'h5A5A, "rd 0010");

    // WE held low: writes land only on IDLE visits (every second edge).
    writeWord(1'b0, 16'h0301, 16'h0AAA, "wr 0301");
    applyStimulus(1'b0, 16'h0300, 1'b1, 1'b0, 16'h1111);
    step();
    checkBit("held we ready 1", a_ready, 1'b1);
    applyStimulus(1'b0, 16'h0301, 1'b1, 1'b0, 16'h2222);
    step();
    checkBit("held we ready 2", a_ready, 1'b0);
    applyStimulus(1'b0, 16'h0302, 1'b1, 1'b0, 16'h3333);
    step();
    checkBit("held we ready 3", a_ready, 1'b1);
    applyStimulus(1'b0, 16'h0302, 1'b1, 1'b1, 16'h0000);
    step();
    checkBit("held we ready 4", a_ready, 1'b0);
    readWord(1'b0, 16'h0300, 16'h1111, "rd 0300");
    readWord(1'b0, 16'h0301, 16'h0AAA, "rd 0301");
    readWord(1'b0, 16'h0302, 16'h3333, "rd 0302");

    writeWord(1'b0, 16'h0200, 16'hCAFE, "wr 0200");

    // Three wait states: OE raised one cycle after accept aborts the read.
    applyStimulus(1'b1, 16'h0005, 1'b0, 1'b1, 16'h0000);
    step();
    checkBit("abort ready accept", b_ready, 1'b0);
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b1, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      step();
      checkBit("abort no ready", b_ready, 1'b0);
    end
    checkOutput("abort rdata", b_rdata, 16'h0000);
    readWord(1'b1, 16'h0001, 16'h8011, "ws3 rd 0001");

    // Address changes during READ are ignored.
    applyStimulus(1'b1, 16'h0002, 1'b0, 1'b1, 16'h0000);
    step();
    applyStimulus(1'b1, 16'h0003, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step();
      checkBit("addr change ready early", b_ready, 1'b0);
    end
    step();
    checkBit("addr change ready", b_ready, 1'b1);
    checkOutput("addr change data", b_rdata, 16'h8022);
    applyStimulus(1'b1, 16'h0003, 1'b1, 1'b1, 16'h0000);
    step();
    checkBit("addr change ready drop", b_ready, 1'b0);

    // Reset in the middle of a read.
    applyStimulus(1'b0, 16'h0200, 1'b0, 1'b1, 16'h0000);
    step();
    reset_n = 1'b0;
    step();
    checkBit("mid reset ready", a_ready, 1'b0);
    checkOutput("mid reset rdata", a_rdata, 16'h0000);
    checkBit("mid reset init_done", a_init_done, 1'b0);
    checkOutput("mid reset rdata ws3", b_rdata, 16'h0000);
    step();
    checkBit("mid reset ready 2", a_ready, 1'b0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
    for (int k = 1; k <= 64; k++) begin
      step();
      checkBit("reinit ready", a_ready, 1'b0);
      checkBit("reinit init_done", a_init_done, (k == 64));
    end
    readWord(1'b0, 16'h0200, 16'hCAFE, "rd 0200 after reset");
    readWord(1'b0, 16'h0010, 16'h8110, "rd 0010 reloaded");
    readWord(1'b0, 16'h0300, 16'h1111, "rd 0300 retained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
